pic_ctrl_seq: RTL and testbench

Synchronous, parametrised control sequencer for the 8259A-compatible PIC. It latches ICW1–ICW4 and OCW1–OCW3 through a clocked initialisation FSM. It runs the INTA acknowledge sequence from a synchronised `inta_n` and produces the interrupt vector. It drives and decodes the cascade bus for master, slave and single-chip operation. It sits between the read/write logic (strobes plus data) and the priority resolver/ISR block (`int_vec`/`int_valid` in, `isr_set`/`eoi_auto` out), and supports a configurable IR-line count.

---
 rtl/pic_ctrl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ctrl_seq.sv
// pic_ctrl_seq: control sequencer for an 8259A-compatible interrupt controller.
// Latches the ICW1..ICW4 initialisation words and the OCW1..OCW3 operation
// words, then runs the two-pulse INTA acknowledge sequence. It produces the
// ISR set request, the automatic-EOI pulse and the interrupt vector. It also
// drives or decodes the cascade bus for master, slave and single-chip setups.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_data                    data byte for every write strobe
//   icw1_wr/icw_wr/ocw1_wr/ocw2_wr/ocw3_wr   one-cycle write strobes
//   sp_n                       1 = master, 0 = slave (cascade mode only)
//   inta_n                     asynchronous acknowledge, active low
//   int_vec, int_valid         highest pending request from the resolver
//   cas_in / cas_out, cas_oe   cascade bus
//   imr, ltim, aeoi, sfnm, read_cmd, ocw2   configuration outputs
//   init_done                  initialisation sequence complete
//   ack1, ack2                 first / second acknowledge phase
//   isr_set, isr_idx           set-ISR-bit pulse and index
//   eoi_auto                   automatic end-of-interrupt pulse
//   vec_out, vec_valid         vector for the data bus
module pic_ctrl_seq #(
  parameter int NUM_IR = 8,
  parameter int CAS_W  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [7:0]                             wr_data,
  input  logic                                   icw1_wr,
  input  logic                                   icw_wr,
  input  logic                                   ocw1_wr,
  input  logic                                   ocw2_wr,
  input  logic                                   ocw3_wr,
  input  logic                                   sp_n,
  input  logic                                   inta_n,
  input  logic [((NUM_IR > 2) ? $clog2(NUM_IR) : 1)-1:0] int_vec,
  input  logic                                   int_valid,
  input  logic [CAS_W-1:0]                       cas_in,
  output logic [CAS_W-1:0]                       cas_out,
  output logic                                   cas_oe,
  output logic [NUM_IR-1:0]                      imr,
  output logic                                   ltim,
  output logic                                   aeoi,
  output logic                                   sfnm,
  output logic [1:0]                             read_cmd,
  output logic [7:0]                             ocw2,
  output logic                                   init_done,
  output logic                                   ack1,
  output logic                                   ack2,
  output logic                                   isr_set,
  output logic [((NUM_IR > 2) ? $clog2(NUM_IR) : 1)-1:0] isr_idx,
  output logic                                   eoi_auto,
  output logic [7:0]                             vec_out,
  output logic                                   vec_valid
);

  localparam int IDX_W = (NUM_IR > 2) ? $clog2(NUM_IR) : 1;

  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} init_t;
  typedef enum logic [1:0] {A_IDLE, A_P1, A_W2, A_P2} ack_t;

  init_t istate, istate_nx;
  ack_t  astate, astate_nx;

  // Only the ICW fields the sequencer actually uses are kept.
  logic              single_q, ic4_q, ltim_q;
  logic [7-IDX_W:0]  vec_base;
  logic [7:0]        icw3;
  logic              aeoi_q, sfnm_q;

  logic              inta_p0, inta_p1, inta_p2;
  logic              inta_fall, inta_rise;

  logic [IDX_W-1:0]  sel_q, sel_nx;
  logic              spur_q, supplier_q, cascaded_q;
  logic              is_master, is_slave, slave_match;
  logic              cascaded_nx, supplier_nx, start, finish;

  // Cascade bit for the selected IR; lines above 7 have no ICW3 bit.
  function automatic logic cascade_bit(input logic [7:0] c3, input logic [IDX_W-1:0] s);
    logic [3:0] s4;
    s4 = 4'(s);
    return (s4 < 4'd8) ? c3[s4[2:0]] : 1'b0;
  endfunction

  assign is_master   = !single_q && sp_n;
  assign is_slave    = !single_q && !sp_n;
  assign slave_match = (cas_in == icw3[CAS_W-1:0]);
  assign sel_nx      = int_valid ? int_vec : IDX_W'(NUM_IR - 1);
  assign cascaded_nx = is_master && cascade_bit(icw3, sel_nx);
  assign supplier_nx = single_q || (is_master && !cascaded_nx) || (is_slave && slave_match);

  // inta_n sync stage 0/1; stage 2 is the previous synced value for edge detect
  assign inta_fall = inta_p2 && !inta_p1;
  assign inta_rise = !inta_p2 && inta_p1;

  assign start  = (astate == A_IDLE) && (istate == READY) && inta_fall && !icw1_wr;
  assign finish = (astate == A_P2) && inta_rise && !icw1_wr;

  always_comb begin
    istate_nx = istate;
    if (icw1_wr) begin
      istate_nx = W_ICW2;
    end else if (icw_wr) begin
      case (istate)
        W_ICW2:  istate_nx = !single_q ? W_ICW3 : (ic4_q ? W_ICW4 : READY);
        W_ICW3:  istate_nx = ic4_q ? W_ICW4 : READY;
        W_ICW4:  istate_nx = READY;
        default: istate_nx = istate;
      endcase
    end
  end

  always_comb begin
    astate_nx = astate;
    if (icw1_wr || (istate != READY)) begin
      astate_nx = A_IDLE;
    end else begin
      case (astate)
        A_IDLE:  if (inta_fall) astate_nx = A_P1;
        A_P1:    if (inta_rise) astate_nx = A_W2;
        A_W2:    if (inta_fall) astate_nx = A_P2;
        A_P2:    if (inta_rise) astate_nx = A_IDLE;
        default: astate_nx = A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      istate     <= UNINIT;
      astate     <= A_IDLE;
      inta_p0    <= 1'b1;
      inta_p1    <= 1'b1;
      inta_p2    <= 1'b1;
      sel_q      <= '0;
      spur_q     <= 1'b0;
      supplier_q <= 1'b0;
      cascaded_q <= 1'b0;
      isr_set    <= 1'b0;
      isr_idx    <= '0;
      eoi_auto   <= 1'b0;
    end else begin
      istate   <= istate_nx;
      astate   <= astate_nx;
      inta_p0  <= inta_n;
      inta_p1  <= inta_p0;
      inta_p2  <= inta_p1;
      isr_set  <= 1'b0;
      eoi_auto <= finish && aeoi_q && !spur_q;
      // Request is frozen at A_P1 entry; slave ID is matched on this cycle too.
      if (start) begin
        sel_q      <= sel_nx;
        spur_q     <= !int_valid;
        supplier_q <= supplier_nx;
        cascaded_q <= cascaded_nx;
        isr_set    <= int_valid && (supplier_nx || is_master);
        isr_idx    <= sel_nx;
      end
    end
  end

  // Register writes, highest-priority strobe only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_q <= 1'b0;
      ic4_q    <= 1'b0;
      ltim_q   <= 1'b0;
      vec_base <= '0;
      icw3     <= '0;
      aeoi_q   <= 1'b0;
      sfnm_q   <= 1'b0;
      imr      <= '0;
      ocw2     <= '0;
      read_cmd <= '0;
    end else if (icw1_wr) begin
      single_q <= wr_data[1];
      ic4_q    <= wr_data[0];
      ltim_q   <= wr_data[3];
      aeoi_q   <= 1'b0;
      sfnm_q   <= 1'b0;
      imr      <= '0;
      ocw2     <= '0;
      read_cmd <= '0;
    end else if (icw_wr) begin
      case (istate)
        W_ICW2:  vec_base <= wr_data[7:IDX_W];
        W_ICW3:  icw3     <= wr_data;
        W_ICW4:  begin
          aeoi_q <= wr_data[1];
          sfnm_q <= wr_data[4];
        end
        default: ;
      endcase
    end else if (istate == READY) begin
      if (ocw1_wr)                     imr      <= NUM_IR'(wr_data);
      else if (ocw2_wr)                ocw2     <= wr_data;
      else if (ocw3_wr && wr_data[1])  read_cmd <= wr_data[1:0];
    end
  end

  assign init_done = (istate == READY);
  assign ltim      = ltim_q;
  assign aeoi      = aeoi_q;
  assign sfnm      = sfnm_q;
  assign ack1      = (astate == A_P1);
  assign ack2      = (astate == A_P2);
  assign vec_valid = ack2 && supplier_q;
  assign vec_out   = vec_valid ? {vec_base, sel_q} : 8'h00;
  assign cas_oe    = (astate != A_IDLE) && cascaded_q;
  assign cas_out   = cas_oe ? CAS_W'(sel_q) : '0;

endmodule

// File: tb/tb_pic_ctrl_seq.sv
module tb_pic_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic icw1_wr = 0, icw_wr = 0, ocw1_wr = 0, ocw2_wr = 0, ocw3_wr = 0;
  logic sp_n = 1'b1, inta_n = 1'b1, int_valid = 1'b0;
  logic [2:0] int_vec8 = 3'd0;
  logic [3:0] int_vec16 = 4'd0;
  logic [2:0] cas_in = 3'd0;

  logic [2:0] cas_out8, cas_out16;
  logic cas_oe8, cas_oe16;
  logic [7:0] imr8;
  logic [15:0] imr16;
  logic ltim8, aeoi8, sfnm8, ltim16, aeoi16, sfnm16;
  logic [1:0] rc8, rc16;
  logic [7:0] ocw2_8, ocw2_16;
  logic done8, done16, ack1_8, ack2_8, ack1_16, ack2_16;
  logic isr8, isr16, eoi8, eoi16, vv8, vv16;
  logic [2:0] idx8;
  logic [3:0] idx16;
  logic [7:0] vo8, vo16;

  always #5 clk = ~clk;

  pic_ctrl_seq #(.NUM_IR(8), .CAS_W(3)) u8 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .icw1_wr(icw1_wr), .icw_wr(icw_wr),
    .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .sp_n(sp_n), .inta_n(inta_n),
    .int_vec(int_vec8), .int_valid(int_valid), .cas_in(cas_in), .cas_out(cas_out8),
    .cas_oe(cas_oe8), .imr(imr8), .ltim(ltim8), .aeoi(aeoi8), .sfnm(sfnm8),
    .read_cmd(rc8), .ocw2(ocw2_8), .init_done(done8), .ack1(ack1_8), .ack2(ack2_8),
    .isr_set(isr8), .isr_idx(idx8), .eoi_auto(eoi8), .vec_out(vo8), .vec_valid(vv8));

  pic_ctrl_seq #(.NUM_IR(16), .CAS_W(3)) u16 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .icw1_wr(icw1_wr), .icw_wr(icw_wr),
    .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr), .sp_n(sp_n), .inta_n(inta_n),
    .int_vec(int_vec16), .int_valid(int_valid), .cas_in(cas_in), .cas_out(cas_out16),
    .cas_oe(cas_oe16), .imr(imr16), .ltim(ltim16), .aeoi(aeoi16), .sfnm(sfnm16),
    .read_cmd(rc16), .ocw2(ocw2_16), .init_done(done16), .ack1(ack1_16), .ack2(ack2_16),
    .isr_set(isr16), .isr_idx(idx16), .eoi_auto(eoi16), .vec_out(vo16), .vec_valid(vv16));

  int n_cmp = 0, n_err = 0;
  logic [7:0] q8[$], q16[$];
  int isr_cnt8 = 0, eoi_cnt8 = 0, vv_cnt8 = 0, cas_cnt8 = 0;
  int isr_cnt16 = 0, vv_cnt16 = 0;
  logic [2:0] last_idx8 = 0, cas_last8 = 0;
  logic [3:0] last_idx16 = 0;
  logic vv8_d = 0, vv16_d = 0, mon16 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: vectors popped when the DUT presents them.
  always @(negedge clk) begin
    if (isr8) begin isr_cnt8++; last_idx8 = idx8; end
    if (eoi8) eoi_cnt8++;
    if (cas_oe8) begin cas_cnt8++; cas_last8 = cas_out8; end
    if (vv8 && !vv8_d) begin
      vv_cnt8++;
      check("vec8_queue", q8.size(), 1);
      if (q8.size() > 0) check("vec8", vo8, q8.pop_front());
    end
    vv8_d = vv8;
    if (mon16) begin
      if (isr16) begin isr_cnt16++; last_idx16 = idx16; end
      if (vv16 && !vv16_d) begin
        vv_cnt16++;
        check("vec16_queue", q16.size(), 1);
        if (q16.size() > 0) check("vec16", vo16, q16.pop_front());
      end
    end
    vv16_d = vv16;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s = {icw1, icw, ocw1, ocw2, ocw3}
  task automatic wr(input logic [4:0] s, input logic [7:0] d);
    {icw1_wr, icw_wr, ocw1_wr, ocw2_wr, ocw3_wr} = s;
    wr_data = d;
    tick();
    {icw1_wr, icw_wr, ocw1_wr, ocw2_wr, ocw3_wr} = 5'b0;
  endtask

  // Full two-pulse INTA; int_vec is changed after ack1 to prove sel is frozen.
  task automatic do_inta(input logic exp_eoi, input logic [3:0] vec_after);
    inta_n = 0; tick(); tick();
    check("ack1_early", ack1_8, 0);
    tick();
    check("ack1_rise", ack1_8, 1);
    int_vec8 = vec_after[2:0]; int_vec16 = vec_after;
    tick(); tick();
    inta_n = 1; tick(); tick();
    check("ack1_hold", ack1_8, 1);
    tick();
    check("ack1_fall", ack1_8, 0);
    tick(); tick();
    inta_n = 0; tick(); tick(); tick();
    check("ack2_rise", ack2_8, 1);
    tick();
    inta_n = 1; tick(); tick(); tick();
    check("ack2_fall", ack2_8, 0);
    check("eoi_coincident", eoi8, exp_eoi);
    tick(); tick();
  endtask

  int b_isr, b_eoi, b_vv, b_cas;
  task automatic snap();
    b_isr = isr_cnt8; b_eoi = eoi_cnt8; b_vv = vv_cnt8; b_cas = cas_cnt8;
  endtask

  initial begin
    tick(); tick();
    check("rst_init_done", done8, 0);
    check("rst_imr", imr8, 0);
    check("rst_vec_out", vo8, 0);
    check("rst_cas_oe", cas_oe8, 0);
    check("rst_ack1", ack1_8, 0);
    check("rst_vec_valid", vv8, 0);
    rst_n = 1; tick();

    // single chip, no ICW4
    wr(5'b10000, 8'h1A);
    check("single_done_early", done8, 0);
    wr(5'b01000, 8'h48);
    check("single_done", done8, 1);
    check("single_ltim", ltim8, 1);
    int_valid = 1; int_vec8 = 3; q8.push_back(8'h4B); snap();
    do_inta(0, 4'd5);
    check("single_isr_cnt", isr_cnt8 - b_isr, 1);
    check("single_isr_idx", last_idx8, 3);
    check("single_vv_cnt", vv_cnt8 - b_vv, 1);

    // master cascade, IR2 has a slave
    sp_n = 1;
    wr(5'b10000, 8'h11); wr(5'b01000, 8'h20); wr(5'b01000, 8'h04);
    check("master_done_early", done8, 0);
    wr(5'b01000, 8'h03);
    check("master_done", done8, 1);
    check("master_aeoi", aeoi8, 1);
    int_vec8 = 2; snap();
    do_inta(1, 4'd2);
    check("master_isr_cnt", isr_cnt8 - b_isr, 1);
    check("master_isr_idx", last_idx8, 2);
    check("master_no_vec", vv_cnt8 - b_vv, 0);
    check("master_eoi_cnt", eoi_cnt8 - b_eoi, 1);
    check("master_cas_seen", (cas_cnt8 - b_cas) > 10, 1);
    check("master_cas_out", cas_last8, 2);
    check("master_cas_oe_end", cas_oe8, 0);

    // slave with ID 2
    sp_n = 0;
    wr(5'b10000, 8'h11); wr(5'b01000, 8'h20); wr(5'b01000, 8'h02); wr(5'b01000, 8'h01);
    check("slave_done", done8, 1);
    cas_in = 2; int_vec8 = 4; q8.push_back(8'h24); snap();
    do_inta(0, 4'd4);
    check("slave_isr_cnt", isr_cnt8 - b_isr, 1);
    check("slave_isr_idx", last_idx8, 4);
    check("slave_vv_cnt", vv_cnt8 - b_vv, 1);
    cas_in = 5; snap();
    do_inta(0, 4'd4);
    check("slave_nomatch_isr", isr_cnt8 - b_isr, 0);
    check("slave_nomatch_vv", vv_cnt8 - b_vv, 0);

    // spurious, single chip with ICW4 and AEOI
    sp_n = 1; cas_in = 0;
    wr(5'b10000, 8'h1B); wr(5'b01000, 8'h40);
    check("spur_done_early", done8, 0);
    wr(5'b01000, 8'h02);
    check("spur_done", done8, 1);
    int_valid = 0; q8.push_back(8'h47); snap();
    do_inta(0, 4'd1);
    check("spur_isr_cnt", isr_cnt8 - b_isr, 0);
    check("spur_eoi_cnt", eoi_cnt8 - b_eoi, 0);
    check("spur_vv_cnt", vv_cnt8 - b_vv, 1);
    int_valid = 1; int_vec8 = 6; q8.push_back(8'h46); snap();
    do_inta(1, 4'd0);
    check("aeoi_eoi_cnt", eoi_cnt8 - b_eoi, 1);

    // 16-line instance and OCW handling
    wr(5'b10000, 8'h1A); wr(5'b01000, 8'h90);
    check("p16_done", done16, 1);
    mon16 = 1;
    int_vec16 = 13; int_vec8 = 5;
    q16.push_back(8'h9D); q8.push_back(8'h95);
    do_inta(0, 4'd13);
    mon16 = 0;
    check("p16_vv_cnt", vv_cnt16, 1);
    check("p16_isr_idx", last_idx16, 13);
    wr(5'b00100, 8'hFF);
    check("imr8", imr8, 8'hFF);
    check("imr16", imr16, 16'h00FF);
    wr(5'b00010, 8'h65);
    check("ocw2", ocw2_8, 8'h65);
    wr(5'b00001, 8'h03);
    check("read_cmd_set", rc8, 3);
    wr(5'b00001, 8'h01);
    check("read_cmd_keep", rc8, 3);
    wr(5'b00001, 8'h02);
    check("read_cmd_2", rc8, 2);

    // abort by icw1_wr during A_W2
    wr(5'b10000, 8'h11);
    check("icw1_clears_imr", imr8, 0);
    wr(5'b00100, 8'h33);
    check("ocw_ignored_uninit", imr8, 0);
    wr(5'b01000, 8'h20); wr(5'b01000, 8'h04); wr(5'b01000, 8'h03);
    wr(5'b00100, 8'hAA);
    check("imr_aa", imr8, 8'hAA);
    int_vec8 = 2; snap();
    inta_n = 0; tick(); tick(); tick();
    check("abort_ack1", ack1_8, 1);
    check("abort_cas_oe", cas_oe8, 1);
    check("abort_cas_out", cas_out8, 2);
    inta_n = 1; tick(); tick(); tick();
    check("abort_w2_cas_oe", cas_oe8, 1);
    wr(5'b10100, 8'h11);
    check("abort_cas_oe_clr", cas_oe8, 0);
    check("abort_ack1_clr", ack1_8, 0);
    check("abort_ack2_clr", ack2_8, 0);
    check("abort_done_clr", done8, 0);
    check("abort_ocw1_dropped", imr8, 0);
    wr(5'b01000, 8'h20); wr(5'b01000, 8'h04); wr(5'b01000, 8'h03);
    check("abort_reinit_done", done8, 1);
    check("abort_no_eoi", eoi_cnt8 - b_eoi, 0);

    // abort by reset during A_W2
    inta_n = 0; tick(); tick(); tick(); tick();
    inta_n = 1; tick(); tick(); tick();
    check("rst_abort_w2", cas_oe8, 1);
    rst_n = 0; #1;
    check("rst_abort_cas_oe", cas_oe8, 0);
    check("rst_abort_ack1", ack1_8, 0);
    check("rst_abort_ack2", ack2_8, 0);
    check("rst_abort_done", done8, 0);
    tick(); rst_n = 1; tick();
    check("sb_empty8", q8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
